nlp16af_bus_responder: RTL



---
 rtl/nlp16af_bus_responder_pkg.sv | 45 ++++
 rtl/nlp16af_bus_responder_if.sv | 22 ++
 rtl/nlp16af_bus_responder_tx_fifo.sv | 56 +++++
 rtl/nlp16af_bus_responder.sv | 111 +++++++++++
 4 files changed

// File: rtl/nlp16af_bus_responder_pkg.sv
// Shared definitions for the nlp16af bus responder: MMIO offsets, STAT bit positions, region decode.
// Optional NLP_BUS_ERR_EN maps the ERRA register at MMIO_BASE+3.
package nlp16af_bus_responder_pkg;

    localparam logic [15:0] OFF_CNT  = 16'd0;
    localparam logic [15:0] OFF_TXD  = 16'd1;
    localparam logic [15:0] OFF_STAT = 16'd2;
    localparam logic [15:0] OFF_ERRA = 16'd3;

    localparam int unsigned STAT_EMPTY   = 0;
    localparam int unsigned STAT_FULL    = 1;
    localparam int unsigned STAT_OVF     = 2;
    localparam int unsigned STAT_CNT_LSB = 4;

    typedef enum logic [2:0] {
        REG_RAM,
        REG_CNT,
        REG_TXD,
        REG_STAT,
        REG_ERRA,
        REG_NONE
    } region_e;

    // RAM wins over MMIO if a parameterisation ever makes the two overlap.
    function automatic region_e decode_region(input logic [15:0] addr,
                                              input int unsigned ram_aw,
                                              input logic [15:0] base);
        logic [15:0] off;
        region_e     r;
        off = addr - base;
        r   = REG_NONE;
        if ((32'(addr) >> ram_aw) == 32'd0) begin
            r = REG_RAM;
        end else if (addr >= base) begin
            if (off == OFF_CNT)       r = REG_CNT;
            else if (off == OFF_TXD)  r = REG_TXD;
            else if (off == OFF_STAT) r = REG_STAT;
`ifdef NLP_BUS_ERR_EN
            else if (off == OFF_ERRA) r = REG_ERRA;
`endif
        end
        return r;
    endfunction

endpackage

// File: rtl/nlp16af_bus_responder_if.sv
// Core-bus and TX-stream signals of the nlp16af bus responder; names are as seen from the responder.
interface nlp16af_bus_responder_if;
    logic        i_wr;
    logic        i_rd;
    logic [15:0] i_addr;
    logic [15:0] i_wdata;
    logic [15:0] o_rdata;
    logic [15:0] o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_bus_err;

    modport slave (
        input  i_wr, i_rd, i_addr, i_wdata, i_tx_ready,
        output o_rdata, o_tx_data, o_tx_valid, o_bus_err
    );

    modport master (
        output i_wr, i_rd, i_addr, i_wdata, i_tx_ready,
        input  o_rdata, o_tx_data, o_tx_valid, o_bus_err
    );
endinterface

// File: rtl/nlp16af_bus_responder_tx_fifo.sv
// Synchronous TX FIFO; a push while full is accepted when a pop happens on the same edge.
module nlp16af_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [15:0]                i_wdata,
    input  logic                       i_ready,
    output logic [15:0]                o_data,
    output logic                       o_valid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_drop
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_pop;
    logic          w_push_ok;

    assign o_valid   = (r_count != '0);
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign w_pop     = o_valid && i_ready;
    assign w_push_ok = i_push && (!o_full || w_pop);
    assign o_drop    = i_push && !w_push_ok;
    assign o_data    = o_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
    end

endmodule

// File: rtl/nlp16af_bus_responder.sv
// nlp16af core-bus target: word RAM, MMIO cycle counter, TX FIFO, STAT.
// Define NLP_BUS_ERR_EN to enable the sticky unmapped-access flag and the ERRA register.
module nlp16af_bus_responder
    import nlp16af_bus_responder_pkg::*;
#(
    parameter int unsigned RAM_AW     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    nlp16af_bus_responder_if.slave  bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [15:0]   r_ram [2**RAM_AW];
    logic [15:0]   r_cnt;
    logic [15:0]   r_rdata;
    logic          r_ovf;
    region_e       w_region;
    logic          w_push;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic [CW-1:0] w_count;
    logic [15:0]   w_stat;
    logic [15:0]   w_erra;
    logic [15:0]   w_rd_mux;

    assign w_region    = decode_region(bus.i_addr, RAM_AW, MMIO_BASE);
    assign w_push      = bus.i_wr && (w_region == REG_TXD);
    assign bus.o_rdata = r_rdata;

    nlp16af_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_wdata (bus.i_wdata),
        .i_ready (bus.i_tx_ready),
        .o_data  (bus.o_tx_data),
        .o_valid (bus.o_tx_valid),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_drop  (w_drop)
    );

    always_ff @(posedge i_clk) begin
        if (bus.i_wr && (w_region == REG_RAM)) r_ram[bus.i_addr[RAM_AW-1:0]] <= bus.i_wdata;
    end

    always_comb begin
        w_stat                        = '0;
        w_stat[STAT_EMPTY]            = w_empty;
        w_stat[STAT_FULL]             = w_full;
        w_stat[STAT_OVF]              = r_ovf;
        w_stat[STAT_CNT_LSB +: 4]     = 4'(w_count);
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_region)
            REG_RAM:  w_rd_mux = r_ram[bus.i_addr[RAM_AW-1:0]];
            REG_CNT:  w_rd_mux = r_cnt;
            REG_STAT: w_rd_mux = w_stat;
            REG_ERRA: w_rd_mux = w_erra;
            default:  w_rd_mux = '0;
        endcase
    end

    // A simultaneous write suppresses the read, so o_rdata keeps its last value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (bus.i_rd && !bus.i_wr) r_rdata <= w_rd_mux;
            if (bus.i_wr && (w_region == REG_CNT)) r_cnt <= '0;
            else                                   r_cnt <= r_cnt + 1'b1;
            if (bus.i_wr && (w_region == REG_STAT)) r_ovf <= 1'b0;
            else if (w_drop)                        r_ovf <= 1'b1;
        end
    end

`ifdef NLP_BUS_ERR_EN
    logic        r_err;
    logic [15:0] r_erra;

    assign bus.o_bus_err = r_err;
    assign w_erra        = r_erra;

    // The first unmapped address is kept until software clears it via ERRA.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err  <= 1'b0;
            r_erra <= '0;
        end else if (bus.i_wr && (w_region == REG_ERRA)) begin
            r_err  <= 1'b0;
            r_erra <= '0;
        end else if ((bus.i_rd || bus.i_wr) && (w_region == REG_NONE) && !r_err) begin
            r_err  <= 1'b1;
            r_erra <= bus.i_addr;
        end
    end
`else
    assign bus.o_bus_err = 1'b0;
    assign w_erra        = '0;
`endif

endmodule
